edulent_fetch_sequencer: RTL and testbench

Instruction fetch sequencer for the edulent CPU. It consumes the per-opcode `read_operand` and `mov_with_address` flag vectors produced by the decode ROM tables and uses them to walk program memory. For each instruction it reads the opcode, an optional operand byte and, for address-form moves, the data byte at that address. It then presents the assembled instruction to the execute stage over a valid/ready handshake.

---
 rtl/edulent_fetch_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_edulent_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edulent_fetch_sequencer.sv
// Instruction fetch sequencer: walks program memory using the decode-ROM flag vectors and
// issues opcode/operand/data to execute. Optional retired counter: EDULENT_FETCH_COUNT_EN.
module edulent_fetch_sequencer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [255:0]  read_operand_rom,
  input  logic [255:0]  mov_with_address_rom,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ready,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_value,
  output logic [AW-1:0] pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [7:0]    instr_opcode,
  output logic [7:0]    instr_operand,
  output logic [7:0]    instr_mem_data,
  output logic          instr_has_operand,
  output logic          instr_is_mov_addr,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {
    OPC   = 2'd0,
    ARG   = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  state_t        seq_state_s;
  logic [AW-1:0] pc_r;
  logic [AW-1:0] pc_s;
  logic [AW-1:0] seq_pc_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_s;
  logic          rd_r;
  logic          rd_s;
  logic          valid_r;
  logic          valid_s;
  logic [7:0]    opcode_r;
  logic [7:0]    opcode_s;
  logic [7:0]    operand_r;
  logic [7:0]    operand_s;
  logic [7:0]    data_r;
  logic [7:0]    data_s;
  logic          has_op_r;
  logic          has_op_s;
  logic          mov_r;
  logic          mov_s;
  logic          fire_s;

  // A read completes only while a request is outstanding; a redirect discards it
  assign fire_s = rd_r & mem_ready & ~pc_load;

  // Sequencing rules per state, before the redirect override
  always_comb begin
    seq_state_s = state_r;
    seq_pc_s    = pc_r;
    opcode_s    = opcode_r;
    operand_s   = operand_r;
    data_s      = data_r;
    has_op_s    = has_op_r;
    mov_s       = mov_r;
    case (state_r)
      OPC: begin
        if (fire_s) begin
          opcode_s    = mem_rdata;
          operand_s   = 8'h00;
          data_s      = 8'h00;
          has_op_s    = read_operand_rom[mem_rdata];
          mov_s       = mov_with_address_rom[mem_rdata];
          seq_pc_s    = pc_r + AW'(1'b1);
          seq_state_s = read_operand_rom[mem_rdata] ? ARG : ISSUE;
        end else begin
          seq_state_s = OPC;
        end
      end
      ARG: begin
        if (fire_s) begin
          operand_s   = mem_rdata;
          seq_pc_s    = pc_r + AW'(1'b1);
          seq_state_s = mov_with_address_rom[opcode_r] ? DATA : ISSUE;
        end else begin
          seq_state_s = ARG;
        end
      end
      DATA: begin
        if (fire_s) begin
          data_s      = mem_rdata;
          seq_state_s = ISSUE;
        end else begin
          seq_state_s = DATA;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          seq_state_s = OPC;
        end else begin
          seq_state_s = ISSUE;
        end
      end
      default: begin
        seq_state_s = OPC;
      end
    endcase
  end

  assign state_s = pc_load ? OPC : seq_state_s;
  assign pc_s    = pc_load ? pc_load_value : seq_pc_s;

  // Bus request and valid are computed from the next state so they leave the flops directly
  always_comb begin
    rd_s    = 1'b0;
    valid_s = 1'b0;
    addr_s  = pc_s;
    case (state_s)
      OPC, ARG: begin
        rd_s   = 1'b1;
        addr_s = pc_s;
      end
      DATA: begin
        rd_s   = 1'b1;
        addr_s = AW'(operand_s);
      end
      ISSUE: begin
        valid_s = 1'b1;
        addr_s  = pc_s;
      end
      default: begin
        rd_s   = 1'b0;
        addr_s = pc_s;
      end
    endcase
  end

  // State, PC, bus request and instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= OPC;
      pc_r      <= '0;
      addr_r    <= '0;
      rd_r      <= 1'b0;
      valid_r   <= 1'b0;
      opcode_r  <= 8'h00;
      operand_r <= 8'h00;
      data_r    <= 8'h00;
      has_op_r  <= 1'b0;
      mov_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      addr_r    <= addr_s;
      rd_r      <= rd_s;
      valid_r   <= valid_s;
      opcode_r  <= opcode_s;
      operand_r <= operand_s;
      data_r    <= data_s;
      has_op_r  <= has_op_s;
      mov_r     <= mov_s;
    end
  end

`ifdef EDULENT_FETCH_COUNT_EN
  logic [15:0] count_r;
  logic        retire_s;

  // A redirect in the accepting cycle still retires the instruction
  assign retire_s = (state_r == ISSUE) & instr_ready;

  // Wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'h0000;
    end else if (retire_s) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;
`else
  assign instr_count = 16'h0000;
`endif

  assign mem_rd            = rd_r;
  assign mem_addr          = addr_r;
  assign pc                = pc_r;
  assign instr_valid       = valid_r;
  assign instr_opcode      = opcode_r;
  assign instr_operand     = operand_r;
  assign instr_mem_data    = data_r;
  assign instr_has_operand = has_op_r;
  assign instr_is_mov_addr = mov_r;

endmodule

// File: tb/tb_edulent_fetch_sequencer.sv
// Self-checking bench for edulent_fetch_sequencer: directed scenarios plus randomized
// programs checked against a per-instruction reference model of the fetch rules.
module tb_edulent_fetch_sequencer;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [255:0]  ro_rom;
  logic [255:0]  mv_rom;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_ready;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic [AW-1:0] pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr_opcode;
  logic [7:0]    instr_operand;
  logic [7:0]    instr_mem_data;
  logic          instr_has_operand;
  logic          instr_is_mov_addr;
  logic [15:0]   instr_count;

  logic [7:0] mem [256];
  logic [7:0] reads [$];
  int         wait_cfg;
  int         wcnt;
  bit         wait_pend;
  bit         last_ld;
  logic [7:0] hold_addr;
  logic [7:0] exp_pc;
  logic [15:0] exp_count;
  int         passed;
  int         failed;
  int         total;

  edulent_fetch_sequencer #(.AW(AW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .read_operand_rom     (ro_rom),
    .mov_with_address_rom (mv_rom),
    .mem_rd               (mem_rd),
    .mem_addr             (mem_addr),
    .mem_rdata            (mem_rdata),
    .mem_ready            (mem_ready),
    .pc_load              (pc_load),
    .pc_load_value        (pc_load_value),
    .pc                   (pc),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr_opcode         (instr_opcode),
    .instr_operand        (instr_operand),
    .instr_mem_data       (instr_mem_data),
    .instr_has_operand    (instr_has_operand),
    .instr_is_mov_addr    (instr_is_mov_addr),
    .instr_count          (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef EDULENT_FETCH_COUNT_EN
    return exp_count;
`else
    return 16'h0000;
`endif
  endfunction

  // Memory responder: answers after wait_cfg wait cycles, logs completed read addresses
  task automatic respond();
    if (last_ld) begin
      wcnt      = 0;
      wait_pend = 1'b0;
    end
    if (mem_rd === 1'b1) begin
      if (wait_pend) chk("addr_hold", 32'(mem_addr), 32'(hold_addr));
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        reads.push_back(mem_addr);
        wcnt      = 0;
        wait_pend = 1'b0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 8'($urandom_range(0, 255));
        wcnt++;
        wait_pend = 1'b1;
        hold_addr = mem_addr;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
      wait_pend = 1'b0;
    end
  endtask

  task automatic tick();
    respond();
    @(posedge clk);
    #1;
    last_ld = pc_load;
    pc_load = 1'b0;
  endtask

  task automatic randomize_env();
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'($urandom_range(0, 255));
      ro_rom[i] = 1'($urandom_range(0, 1));
      mv_rom[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    pc_load     = 1'b0;
    instr_ready = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = 8'h00;
    #1;
    chk("rst_mem_rd", 32'(mem_rd), 32'(1'b0));
    chk("rst_pc", 32'(pc), 32'(8'h00));
    chk("rst_valid", 32'(instr_valid), 32'(1'b0));
    chk("rst_opcode", 32'(instr_opcode), 32'(8'h00));
    chk("rst_operand", 32'(instr_operand), 32'(8'h00));
    chk("rst_mem_data", 32'(instr_mem_data), 32'(8'h00));
    chk("rst_has_op", 32'(instr_has_operand), 32'(1'b0));
    chk("rst_mov", 32'(instr_is_mov_addr), 32'(1'b0));
    chk("rst_count", 32'(instr_count), 32'(16'h0000));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    wcnt      = 0;
    wait_pend = 1'b0;
    last_ld   = 1'b0;
    exp_pc    = 8'h00;
    exp_count = 16'h0000;
    chk("deassert_mem_rd", 32'(mem_rd), 32'(1'b0));
    tick();
  endtask

  // One instruction from request to acceptance, checked against the fetch rules
  task automatic run_instr(input int w, input int bp, input bit ld, input logic [7:0] ldv);
    logic [7:0] pc0;
    logic [7:0] op;
    logic [7:0] opnd;
    logic [7:0] dat;
    logic [7:0] npc;
    logic [7:0] ea [3];
    bit         ro;
    bit         mv;
    int         nrd;
    int         cyc;
    reads.delete();
    wait_cfg = w;
    pc0  = exp_pc;
    op   = mem[pc0];
    ro   = ro_rom[op];
    mv   = mv_rom[op];
    opnd = ro ? mem[pc0 + 8'd1] : 8'h00;
    dat  = (ro && mv) ? mem[opnd] : 8'h00;
    nrd  = 1 + int'(ro) + int'(ro && mv);
    npc  = pc0 + 8'd1 + (ro ? 8'd1 : 8'd0);
    ea[0] = pc0;
    ea[1] = pc0 + 8'd1;
    ea[2] = opnd;
    chk("req_start", 32'(mem_rd), 32'(1'b1));
    chk("req_addr", 32'(mem_addr), 32'(pc0));
    cyc = 1;
    while (instr_valid !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
    chk("valid_cycle", 32'(cyc), 32'(nrd * (w + 1) + 1));
    for (int b = 0; b <= bp; b++) begin
      chk("valid", 32'(instr_valid), 32'(1'b1));
      chk("opcode", 32'(instr_opcode), 32'(op));
      chk("operand", 32'(instr_operand), 32'(opnd));
      chk("mem_data", 32'(instr_mem_data), 32'(dat));
      chk("has_operand", 32'(instr_has_operand), 32'(ro));
      chk("is_mov_addr", 32'(instr_is_mov_addr), 32'(mv));
      chk("issue_pc", 32'(pc), 32'(npc));
      chk("issue_no_rd", 32'(mem_rd), 32'(1'b0));
      if (b < bp) tick();
    end
    chk("read_count", 32'(reads.size()), 32'(nrd));
    for (int i = 0; i < nrd && i < reads.size(); i++) begin
      chk("read_addr", 32'(reads[i]), 32'(ea[i]));
    end
    instr_ready   = 1'b1;
    pc_load       = ld;
    pc_load_value = ldv;
    tick();
    instr_ready = 1'b0;
    exp_count   = exp_count + 16'h0001;
    exp_pc      = ld ? ldv : npc;
    chk("count", 32'(instr_count), 32'(cnt_exp()));
    chk("accept_valid_drop", 32'(instr_valid), 32'(1'b0));
    chk("next_pc", 32'(pc), 32'(exp_pc));
    chk("next_req", 32'(mem_rd), 32'(1'b1));
  endtask

  initial begin
    pc_load       = 1'b0;
    pc_load_value = 8'h00;
    instr_ready   = 1'b0;
    mem_ready     = 1'b0;
    mem_rdata     = 8'h00;
    wait_cfg      = 0;
    randomize_env();
    ro_rom[8'h00] = 1'b0;
    ro_rom[8'h19] = 1'b1;
    mv_rom[8'h19] = 1'b0;
    ro_rom[8'h11] = 1'b1;
    mv_rom[8'h11] = 1'b1;
    mem[8'h00] = 8'h00;
    mem[8'h01] = 8'h19;
    mem[8'h02] = 8'h7A;
    mem[8'h03] = 8'h11;
    mem[8'h04] = 8'h40;
    mem[8'h05] = 8'h19;
    mem[8'h06] = 8'h55;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h40;
    mem[8'h40] = 8'hC3;
    mem[8'hFF] = 8'h19;
    #2;
    do_reset();

    run_instr(0, 0, 1'b0, 8'h00);
    run_instr(0, 2, 1'b0, 8'h00);
    run_instr(0, 1, 1'b0, 8'h00);

    // Redirect in the ARG cycle that also completes the operand read
    wait_cfg = 0;
    chk("redir_opc_addr", 32'(mem_addr), 32'(8'h05));
    tick();
    chk("redir_arg_addr", 32'(mem_addr), 32'(8'h06));
    pc_load       = 1'b1;
    pc_load_value = 8'h20;
    tick();
    chk("redir_rd", 32'(mem_rd), 32'(1'b1));
    chk("redir_addr", 32'(mem_addr), 32'(8'h20));
    chk("redir_pc", 32'(pc), 32'(8'h20));
    chk("redir_no_valid", 32'(instr_valid), 32'(1'b0));
    chk("redir_operand_discard", 32'(instr_operand), 32'(8'h00));
    exp_pc = 8'h20;

    run_instr(3, 5, 1'b1, 8'hFF);
    run_instr(0, 1, 1'b0, 8'h00);

    // Asynchronous reset while a read is pending
    wait_cfg = 3;
    tick();
    chk("midfetch_pending", 32'(mem_rd), 32'(1'b1));
    randomize_env();
    do_reset();

    for (int n = 0; n < 25; n++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
